match_overlay: RTL and testbench
================================

MATCH_OVERLAY -- requirements
Module: match_overlay

Interface
REQ-001 Parameters SHALL be: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, BOX_W 40, BOX_H 100, BOX_COLOR 24'hFF0000.
REQ-002 clk  input  1  single clock, rising edge; all state SHALL be clocked by it.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  advance enable; low freezes all state.
REQ-005 xpos  input  10  column of the matched template's top-left corner, from the matcher.
REQ-006 ypos  input  10  row of the matched template's top-left corner, from the matcher.
REQ-007 pix_in  input  8  grayscale pixel for the coordinate currently on hcount/vcount.
REQ-008 hcount  output  10  registered raster column, 0..799.
REQ-009 vcount  output  10  registered raster row, 0..524.
REQ-010 hsync  output  1  horizontal sync, active-low.
REQ-011 vsync  output  1  vertical sync, active-low.
REQ-012 de  output  1  active-video flag.
REQ-013 pix_out  output  24  RGB pixel {R,G,B}.
REQ-014 frame_start  output  1  one-cycle pulse aligned with output of pixel (0,0).

Function
REQ-015 With ena high, hcount SHALL increment each cycle and wrap 799->0; vcount SHALL increment when hcount wraps and wrap 524->0 when both wrap together.
REQ-016 With ena low, every register (counters, latched box, output stage) SHALL hold its value.
REQ-017 Output stage (hsync, vsync, de, pix_out, frame_start) SHALL be registered, with 1-cycle latency relative to the hcount/vcount/pix_in values it was computed from.
REQ-018 hsync SHALL be 0 for hcount 656..751 and 1 otherwise; vsync SHALL be 0 for vcount 490..491 and 1 otherwise.
REQ-019 de SHALL be 1 for hcount<640 and vcount<480, and 0 otherwise.
REQ-020 When ena is high and hcount==0 and vcount==0, box_x/box_y SHALL latch xpos/ypos; box_on SHALL latch (xpos!=0 or ypos!=0).
REQ-021 The box SHALL remain fixed for the whole frame; xpos/ypos changes mid-frame SHALL take effect only at the next (0,0).
REQ-022 Box extent SHALL be computed 11 bits wide: x_end = box_x+BOX_W-1, y_end = box_y+BOX_H-1; no wrap-around.
REQ-023 A pixel is a border pixel when box_on, box_x<=h<=x_end, box_y<=v<=y_end, and (h==box_x or h==x_end or v==box_y or v==y_end).
REQ-024 Border parts beyond the active area SHALL be clipped (not drawn) and SHALL NOT alias into blanking or wrap to column/row 0.
REQ-025 pix_out SHALL be BOX_COLOR on active border pixels, {pix_in,pix_in,pix_in} on other active pixels, and 24'h000000 when de would be 0.
REQ-026 frame_start SHALL be 1 exactly in the output cycle for source (0,0), and 0 otherwise.

Reset
REQ-027 rst low SHALL asynchronously set hcount=0, vcount=0, box_x=0, box_y=0, box_on=0, pix_out=0, de=0, frame_start=0, hsync=1, vsync=1.
REQ-028 After rst rises, the first enabled cycle SHALL latch the box (counters at 0,0), and frame_start SHALL pulse on the following cycle.
REQ-029 Reset asserted mid-frame SHALL abandon the frame and restart at (0,0) with the box disabled until the next latch.

Verification
REQ-030 Free-run 2 frames with ena=1 -> exactly 800 cycles per line and 420000 per frame; hsync low for 96 cycles starting at hcount 656; vsync low for 2 lines at rows 490..491; frame_start high once per frame.
REQ-031 xpos=100, ypos=50, pix_in=8'h40 -> pix_out=FF0000 at (100..139,50), (100..139,149), (100,50..149), (139,50..149); 404040 at (120,100) and at other active pixels.
REQ-032 xpos=620, ypos=400 -> border drawn only for columns 620..639 and rows 400..479; no BOX_COLOR on column 0 or row 0; pix_out=0 during blanking.
REQ-033 Change xpos from 100 to 300 at row 200 -> current frame keeps the box at column 100; next frame draws it at column 300.
REQ-034 Hold ena low for 37 cycles mid-line -> all outputs and counters frozen; the sequence resumes with no skipped or repeated coordinate.
REQ-035 Assert rst at (400,300) -> outputs immediately take their reset values; after release, xpos=0, ypos=0 -> no box drawn.

Source files
------------

// File: rtl/match_overlay.sv
// ---------------------------------------------------------------------------
// match_overlay
//
// Generates a VGA-style raster (hcount/vcount plus syncs and active-video
// flag). For each active pixel it either passes the incoming grayscale pixel
// through as gray RGB, or paints it BOX_COLOR when the pixel lies on the
// one-pixel border of a BOX_W x BOX_H rectangle. The rectangle's top-left
// corner comes from a template matcher (xpos/ypos). It is sampled once per
// frame, at raster origin (0,0), so the box never tears mid-frame.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          asynchronous reset, active low
//   ena          advance enable; low freezes every register
//   xpos, ypos   matched template top-left corner (column, row)
//   pix_in       grayscale pixel for the coordinate on hcount/vcount
//   hcount       registered raster column
//   vcount       registered raster row
//   hsync        horizontal sync, active low (registered, 1-cycle latency)
//   vsync        vertical sync, active low (registered, 1-cycle latency)
//   de           active-video flag (registered, 1-cycle latency)
//   pix_out      RGB output {R,G,B} (registered, 1-cycle latency)
//   frame_start  one-cycle pulse aligned with the output of pixel (0,0)
// ---------------------------------------------------------------------------
module match_overlay #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter int          BOX_W     = 40,
    parameter int          BOX_H     = 100,
    parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [9:0]  xpos,
    input  logic [9:0]  ypos,
    input  logic [7:0]  pix_in,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [23:0] pix_out,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_LIM = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_LIM = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] BOX_W_M1  = 11'(BOX_W - 1);
    localparam logic [10:0] BOX_H_M1  = 11'(BOX_H - 1);

    // Raster counters and per-frame box latch
    logic [9:0]  hcount_reg, hcount_next;
    logic [9:0]  vcount_reg, vcount_next;
    logic [9:0]  box_x_reg, box_x_next;
    logic [9:0]  box_y_reg, box_y_next;
    logic        box_on_reg, box_on_next;

    // Output stage
    logic        hsync_reg, hsync_next;
    logic        vsync_reg, vsync_next;
    logic        de_reg, de_next;
    logic [23:0] pix_reg, pix_next;
    logic        fs_reg, fs_next;

    // Border geometry, all 11 bits wide so x_end/y_end never wrap
    logic        at_origin;
    logic [10:0] h_ext, v_ext;
    logic [10:0] bx_ext, by_ext;
    logic [10:0] x_end, y_end;
    logic        in_x, in_y, on_edge, border;

    always_comb begin
        hcount_next = hcount_reg + 10'd1;
        vcount_next = vcount_reg;
        if (hcount_reg == H_LAST) begin
            hcount_next = 10'd0;
            vcount_next = (vcount_reg == V_LAST) ? 10'd0 : vcount_reg + 10'd1;
        end
    end

    // The box is picked up at the origin pixel itself, so the pixel (0,0)
    // output already uses the new frame's box; it then stays fixed until
    // the next origin.
    assign at_origin   = (hcount_reg == 10'd0) && (vcount_reg == 10'd0);
    assign box_x_next  = at_origin ? xpos : box_x_reg;
    assign box_y_next  = at_origin ? ypos : box_y_reg;
    assign box_on_next = at_origin ? ((xpos != 10'd0) || (ypos != 10'd0)) : box_on_reg;

    assign h_ext  = {1'b0, hcount_reg};
    assign v_ext  = {1'b0, vcount_reg};
    assign bx_ext = {1'b0, box_x_next};
    assign by_ext = {1'b0, box_y_next};
    assign x_end  = bx_ext + BOX_W_M1;
    assign y_end  = by_ext + BOX_H_M1;

    assign in_x    = (h_ext >= bx_ext) && (h_ext <= x_end);
    assign in_y    = (v_ext >= by_ext) && (v_ext <= y_end);
    assign on_edge = (h_ext == bx_ext) || (h_ext == x_end) ||
                     (v_ext == by_ext) || (v_ext == y_end);
    assign border  = box_on_next && in_x && in_y && on_edge;

    // Clipping falls out of gating the border with the active-area test:
    // border coordinates past the active edge are simply never painted.
    always_comb begin
        de_next    = (h_ext < H_ACT_LIM) && (v_ext < V_ACT_LIM);
        hsync_next = !((h_ext >= HS_START) && (h_ext < HS_END));
        vsync_next = !((v_ext >= VS_START) && (v_ext < VS_END));
        fs_next    = at_origin;
        pix_next   = 24'h000000;
        if (de_next) begin
            pix_next = border ? BOX_COLOR : {pix_in, pix_in, pix_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_reg <= 10'd0;
            vcount_reg <= 10'd0;
            box_x_reg  <= 10'd0;
            box_y_reg  <= 10'd0;
            box_on_reg <= 1'b0;
            hsync_reg  <= 1'b1;
            vsync_reg  <= 1'b1;
            de_reg     <= 1'b0;
            pix_reg    <= 24'h000000;
            fs_reg     <= 1'b0;
        end else if (ena) begin
            hcount_reg <= hcount_next;
            vcount_reg <= vcount_next;
            box_x_reg  <= box_x_next;
            box_y_reg  <= box_y_next;
            box_on_reg <= box_on_next;
            hsync_reg  <= hsync_next;
            vsync_reg  <= vsync_next;
            de_reg     <= de_next;
            pix_reg    <= pix_next;
            fs_reg     <= fs_next;
        end
    end

    assign hcount      = hcount_reg;
    assign vcount      = vcount_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign de          = de_reg;
    assign pix_out     = pix_reg;
    assign frame_start = fs_reg;

endmodule

// File: tb/tb_match_overlay.sv
// ---------------------------------------------------------------------------
// tb_match_overlay
//
// Directed bench for match_overlay. The DUT runs with a scaled-down raster
// (80 x 55 total, 64 x 48 active, 8 x 10 box) so several whole frames fit in
// a short run; every scenario of the full-size raster maps onto it:
//   hsync low for h 68..75, vsync low for rows 50..51, 4400 cycles per frame.
// ---------------------------------------------------------------------------
module tb_match_overlay;

    localparam int HT = 80;
    localparam int VT = 55;
    localparam int FRAME = HT * VT;
    localparam logic [23:0] RED  = 24'hFF0000;
    localparam logic [23:0] GRAY = 24'h404040;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [9:0]  xpos;
    logic [9:0]  ypos;
    logic [7:0]  pix_in;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [23:0] pix_out;
    logic        frame_start;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Results of the most recent scan_frame
    int coord_err, de_err, hs_low, hs_first, vs_low, vs_first, de_n;
    int fs_n, fs_cyc, box_n, box_edge, gray_n, blank_nz;

    match_overlay #(
        .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (48), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .BOX_W    (8),  .BOX_H (10), .BOX_COLOR (24'hFF0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .xpos        (xpos),
        .ypos        (ypos),
        .pix_in      (pix_in),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .pix_out     (pix_out),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance until the DUT shows the given coordinate, then clock it through
    // the output stage and return the resulting pixel.
    task automatic pix_at(input int h, input int v, output logic [23:0] p);
        int n = 0;
        while (!(hcount == 10'(h) && vcount == 10'(v)) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        if (n >= 2 * FRAME) begin
            total++; bad++;
            $display("FAIL pix_at_timeout h=%0d v=%0d got hcount=%0d vcount=%0d", h, v, hcount, vcount);
        end
        tick();
        p = pix_out;
    endtask

    task automatic sync_origin();
        int n = 0;
        while (!(hcount == 10'd0 && vcount == 10'd0) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        if (n >= 2 * FRAME) begin
            total++; bad++;
            $display("FAIL sync_timeout got hcount=%0d vcount=%0d want 0/0", hcount, vcount);
        end
    endtask

    // Run one full frame from origin, collecting statistics on every output.
    task automatic scan_frame();
        int sh, sv, nh, nv;
        sync_origin();
        coord_err = 0; de_err = 0; hs_low = 0; hs_first = -1; vs_low = 0;
        vs_first = -1; de_n = 0; fs_n = 0; fs_cyc = -1; box_n = 0;
        box_edge = 0; gray_n = 0; blank_nz = 0;
        for (int t = 0; t < FRAME; t++) begin
            sh = int'(hcount);
            sv = int'(vcount);
            tick();
            nh = (sh == HT - 1) ? 0 : sh + 1;
            nv = (sh == HT - 1) ? ((sv == VT - 1) ? 0 : sv + 1) : sv;
            if (int'(hcount) != nh || int'(vcount) != nv) coord_err++;
            if (de !== ((sh < 64) && (sv < 48))) de_err++;
            if (hsync === 1'b0) begin
                hs_low++;
                if (hs_first < 0 && sv == 0) hs_first = sh;
            end
            if (vsync === 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = sv;
            end
            if (de === 1'b1) de_n++;
            if (frame_start === 1'b1) begin
                fs_n++;
                fs_cyc = cyc;
            end
            if (pix_out === RED) begin
                box_n++;
                if (sh == 0 || sv == 0 || sh >= 64 || sv >= 48) box_edge++;
            end else if (pix_out === GRAY) begin
                gray_n++;
            end
            if (de !== 1'b1 && pix_out !== 24'h0) blank_nz++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; ena = 1'b1; xpos = 10'd0; ypos = 10'd0; pix_in = 8'h40;
        tick(); tick();
        total++; if (hcount !== 10'd0) begin bad++; $display("FAIL reset_hcount got=%0d want=0", hcount); end
        total++; if (vcount !== 10'd0) begin bad++; $display("FAIL reset_vcount got=%0d want=0", vcount); end
        total++; if (hsync !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b want=1", hsync); end
        total++; if (vsync !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b want=1", vsync); end
        total++; if (de !== 1'b0) begin bad++; $display("FAIL reset_de got=%b want=0", de); end
        total++; if (pix_out !== 24'h0) begin bad++; $display("FAIL reset_pix got=%h want=000000", pix_out); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", frame_start); end
        $display("test_reset: hcount=%0d vcount=%0d pix=%h", hcount, vcount, pix_out);
    endtask

    task automatic test_first_frame();
        rst = 1'b1;
        tick();
        total++; if (hcount !== 10'd1 || vcount !== 10'd0) begin bad++; $display("FAIL first_coord got=%0d,%0d want=1,0", hcount, vcount); end
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL first_fs got=%b want=1", frame_start); end
        total++; if (pix_out !== GRAY) begin bad++; $display("FAIL first_pix got=%h want=404040", pix_out); end
        tick();
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL first_fs_drop got=%b want=0", frame_start); end
        $display("test_first_frame: fs pulse after release checked");
    endtask

    task automatic test_timing();
        int c1;
        scan_frame();
        c1 = fs_cyc;
        scan_frame();
        total++; if (fs_cyc - c1 !== FRAME) begin bad++; $display("FAIL frame_len got=%0d want=%0d", fs_cyc - c1, FRAME); end
        total++; if (coord_err !== 0) begin bad++; $display("FAIL coord_seq got=%0d errors want=0", coord_err); end
        total++; if (hs_low !== 8 * VT) begin bad++; $display("FAIL hs_low got=%0d want=%0d", hs_low, 8 * VT); end
        total++; if (hs_first !== 68) begin bad++; $display("FAIL hs_first got=%0d want=68", hs_first); end
        total++; if (vs_low !== 2 * HT) begin bad++; $display("FAIL vs_low got=%0d want=%0d", vs_low, 2 * HT); end
        total++; if (vs_first !== 50) begin bad++; $display("FAIL vs_first got=%0d want=50", vs_first); end
        total++; if (de_n !== 3072 || de_err !== 0) begin bad++; $display("FAIL de_count got=%0d err=%0d want=3072 err=0", de_n, de_err); end
        total++; if (fs_n !== 1) begin bad++; $display("FAIL fs_count got=%0d want=1", fs_n); end
        total++; if (box_n !== 0 || gray_n !== 3072) begin bad++; $display("FAIL nobox_pix got box=%0d gray=%0d want 0/3072", box_n, gray_n); end
        $display("test_timing: frame=%0d hs_low=%0d vs_low=%0d de=%0d", fs_cyc - c1, hs_low, vs_low, de_n);
    endtask

    task automatic test_box();
        int          ph [10] = '{10, 13, 17, 18,  9, 10, 12, 17, 14, 14};
        int          pv [10] = '{ 5,  5,  5,  5,  9,  9,  9,  9, 14, 15};
        logic [23:0] pe [10] = '{RED, RED, RED, GRAY, GRAY, RED, GRAY, RED, RED, GRAY};
        logic [23:0] p;
        xpos = 10'd10; ypos = 10'd5;
        sync_origin();
        for (int i = 0; i < 10; i++) begin
            pix_at(ph[i], pv[i], p);
            total++;
            if (p !== pe[i]) begin bad++; $display("FAIL box_pix (%0d,%0d) got=%h want=%h", ph[i], pv[i], p, pe[i]); end
            $display("test_box: (%0d,%0d) pix=%h", ph[i], pv[i], p);
        end
    endtask

    task automatic test_clip();
        xpos = 10'd60; ypos = 10'd44;
        scan_frame();
        total++; if (box_n !== 7) begin bad++; $display("FAIL clip_box_count got=%0d want=7", box_n); end
        total++; if (box_edge !== 0) begin bad++; $display("FAIL clip_alias got=%0d want=0", box_edge); end
        total++; if (blank_nz !== 0) begin bad++; $display("FAIL clip_blank got=%0d want=0", blank_nz); end
        total++; if (gray_n !== 3065) begin bad++; $display("FAIL clip_gray got=%0d want=3065", gray_n); end
        $display("test_clip: box=%0d gray=%0d blank_nz=%0d", box_n, gray_n, blank_nz);
    endtask

    task automatic test_mid_change();
        logic [23:0] p;
        xpos = 10'd10; ypos = 10'd5;
        sync_origin();
        pix_at(10, 5, p);
        total++; if (p !== RED) begin bad++; $display("FAIL chg_pre got=%h want=ff0000", p); end
        pix_at(0, 8, p);
        xpos = 10'd30;
        pix_at(10, 9, p);
        total++; if (p !== RED) begin bad++; $display("FAIL chg_old_col got=%h want=ff0000", p); end
        pix_at(30, 9, p);
        total++; if (p !== GRAY) begin bad++; $display("FAIL chg_new_early got=%h want=404040", p); end
        pix_at(10, 9, p);
        total++; if (p !== GRAY) begin bad++; $display("FAIL chg_old_next got=%h want=404040", p); end
        pix_at(30, 9, p);
        total++; if (p !== RED) begin bad++; $display("FAIL chg_new_next got=%h want=ff0000", p); end
        $display("test_mid_change: box moved 10->30 at next frame");
    endtask

    task automatic test_freeze();
        logic [9:0]  h0, v0;
        logic [23:0] p0;
        logic        hs0, de0;
        int          err = 0;
        h0 = hcount; v0 = vcount; p0 = pix_out; hs0 = hsync; de0 = de;
        ena = 1'b0;
        pix_in = 8'h99;
        for (int i = 0; i < 37; i++) begin
            tick();
            if (hcount !== h0 || vcount !== v0 || pix_out !== p0 || hsync !== hs0 || de !== de0 || frame_start !== 1'b0) err++;
        end
        total++; if (err !== 0) begin bad++; $display("FAIL freeze_hold got=%0d changes want=0", err); end
        pix_in = 8'h40;
        ena = 1'b1;
        tick();
        total++; if (hcount !== h0 + 10'd1 || vcount !== v0) begin bad++; $display("FAIL freeze_resume got=%0d,%0d want=%0d,%0d", hcount, vcount, h0 + 10'd1, v0); end
        $display("test_freeze: held at (%0d,%0d) pix=%h for 37 cycles", h0, v0, p0);
    endtask

    task automatic test_mid_reset();
        logic [23:0] p;
        pix_at(40, 30, p);
        total++; if (p !== GRAY || de !== 1'b1) begin bad++; $display("FAIL rst_pre got=%h de=%b want=404040 de=1", p, de); end
        rst = 1'b0;
        #2;
        total++; if (hcount !== 10'd0 || vcount !== 10'd0) begin bad++; $display("FAIL rst_async_coord got=%0d,%0d want=0,0", hcount, vcount); end
        total++; if (pix_out !== 24'h0 || de !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1) begin bad++; $display("FAIL rst_async_out got pix=%h de=%b hs=%b vs=%b", pix_out, de, hsync, vsync); end
        xpos = 10'd0; ypos = 10'd0;
        tick(); tick();
        total++; if (hcount !== 10'd0) begin bad++; $display("FAIL rst_hold got=%0d want=0", hcount); end
        rst = 1'b1;
        scan_frame();
        total++; if (box_n !== 0 || fs_n !== 1) begin bad++; $display("FAIL rst_nobox got box=%0d fs=%0d want 0/1", box_n, fs_n); end
        total++; if (coord_err !== 0) begin bad++; $display("FAIL rst_coord got=%0d want=0", coord_err); end
        $display("test_mid_reset: box=%0d fs=%0d after restart", box_n, fs_n);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_timing();
        test_box();
        test_clip();
        test_mid_change();
        test_freeze();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
